// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: shared type codes, state and error encodings for the data-memory controller
package dmem_access_ctrl_pkg;
  localparam logic [2:0] LD_WORD = 3'd0, LD_HALF = 3'd1, LD_HALFU = 3'd2, LD_BYTE = 3'd3, LD_BYTEU = 3'd4;
  localparam logic [2:0] ST_WORD = 3'd0, ST_HALF = 3'd1, ST_BYTE = 3'd3;
  localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2, S_ERR = 2'd3;
  localparam logic ERR_MISALIGN = 1'b0, ERR_BUS = 1'b1;
  typedef logic [1:0] size_t;
  localparam size_t SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2;
  // Store codes share the load codes' size positions, so one decode serves both.
  function automatic size_t size_of(input logic [2:0] t);
    return (t == LD_HALF || t == LD_HALFU) ? SZ_HALF : (t == LD_BYTE || t == LD_BYTEU) ? SZ_BYTE : SZ_WORD;
  endfunction
  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] a);
    return size_of(t) == SZ_HALF ? a[0] : size_of(t) == SZ_WORD ? |a : 1'b0;
  endfunction
endpackage

// File: rtl/dmem_access_ctrl_load_lane_extract.sv
// load_lane_extract: selects the addressed lane of a read word and sign/zero-extends it
module load_lane_extract
  import dmem_access_ctrl_pkg::*;
(
  input  logic [2:0]  type_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);
  logic [15:0] lane_h;
  logic [7:0]  lane_b;
  // Lane select then extension; unknown codes pass the whole word
  always_comb begin
    lane_h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    lane_b = rdata_i[{addr_i, 3'b000} +: 8];
    data_o = type_i == LD_HALF  ? {{16{lane_h[15]}}, lane_h} :
             type_i == LD_HALFU ? {16'h0, lane_h} :
             type_i == LD_BYTE  ? {{24{lane_b[7]}}, lane_b} :
             type_i == LD_BYTEU ? {24'h0, lane_b} : rdata_i;
  end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences one CPU load/store onto a wait-stated word memory with error reporting
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  logic [1:0]  state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] rdata_q, rdata_d, addr_q, wdata_q, ext;
  logic [2:0]  type_q;
  logic        we_q, err_q, err_d, idle, busy, bad, take;
  size_t       sz;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  assign idle = state_q == S_IDLE;
  assign busy = state_q == S_BUSY;
  assign bad  = misaligned(req_type, req_addr[1:0]);
  assign take = idle & req_valid & ~bad;
  load_lane_extract u_extract (
    .type_i (type_q),
    .addr_i (addr_q[1:0]),
    .rdata_i(mem_rdata),
    .data_o (ext)
  );
  // Next state; an ack in the expiring cycle wins over the timeout
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (idle && req_valid) begin
      state_d = bad ? S_ERR : S_BUSY;
      err_d   = bad ? ERR_MISALIGN : err_q;
      timer_d = 8'd0;
    end else if (busy && mem_ack) begin
      state_d = S_RESP;
      rdata_d = we_q ? rdata_q : ext;
    end else if (busy) begin
      timer_d = timer_q + 8'd1;
      state_d = ({1'b0, timer_q} + 9'd1 == 9'(TIMEOUT)) ? S_ERR : S_BUSY;
      err_d   = ERR_BUS;
    end else if (!idle) begin
      state_d = S_IDLE;
    end
  end
  // State registers and request capture on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      rdata_q <= '0;
      err_q   <= ERR_MISALIGN;
      we_q    <= 1'b0;
      type_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (take) begin
        we_q    <= req_we;
        type_q  <= req_type;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end
  // Store byte enables and lane replication from the latched request
  always_comb begin
    sz      = size_of(type_q);
    st_be   = sz == SZ_WORD ? 4'hF : sz == SZ_HALF ? (addr_q[1] ? 4'hC : 4'h3) : 4'b0001 << addr_q[1:0];
    st_data = sz == SZ_WORD ? wdata_q : sz == SZ_HALF ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
  end
  assign mem_req   = busy;
  assign mem_we    = busy & we_q;
  assign mem_addr  = busy ? {addr_q[31:2], 2'b00} : '0;
  assign mem_be    = busy ? (we_q ? st_be : 4'hF) : '0;
  assign mem_wdata = (busy & we_q) ? st_data : '0;
  assign stall     = (idle & req_valid) | busy;
  assign done      = state_q == S_RESP;
  assign misalign  = (state_q == S_ERR) & (err_q == ERR_MISALIGN);
  assign bus_err   = (state_q == S_ERR) & (err_q == ERR_BUS);
  assign rdata     = rdata_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: randomized transactions checked against a transaction-level model
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, mem_ack = 1'b0;
  logic [2:0] req_type = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic stall, done, misalign, bus_err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int n_checks = 0, n_errors = 0;
  logic [31:0] exp_rdata = '0;

  dmem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .done(done), .rdata(rdata),
    .misalign(misalign), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [2:0] t);
    case (t)
      LD_HALF, LD_HALFU: return 2;
      LD_BYTE, LD_BYTEU: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] lane;
    lane = w >> (8 * (a % 4));
    if (nbytes(t) == 4) return w;
    if (nbytes(t) == 2) return t == LD_HALF ? 32'($signed(lane[15:0])) : {16'h0, lane[15:0]};
    return t == LD_BYTE ? 32'($signed(lane[7:0])) : {24'h0, lane[7:0]};
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] t, input logic [31:0] w);
    return nbytes(t) == 4 ? w : nbytes(t) == 2 ? {2{w[15:0]}} : {4{w[7:0]}};
  endfunction

  task automatic run_txn(input logic we, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] w, input logic [31:0] rw, input int waits);
    int n;
    logic mis, acked;
    logic [3:0] ebe;
    n = nbytes(t);
    mis = (a % n) != 0;
    ebe = we ? 4'(((1 << n) - 1) << (a % 4)) : 4'hF;
    tick();
    req_valid = 1'b1; req_we = we; req_type = t; req_addr = a; req_wdata = w;
    mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    chk("stall_c0", stall, 1);
    chk("mreq_c0", mem_req, 0);
    chk("done_c0", done, 0);
    if (mis) begin
      tick();
      mem_ack = 1'($urandom);
      #1;
      chk("misalign", misalign, 1);
      chk("mis_stall", stall, 0);
      chk("mis_mreq", mem_req, 0);
      chk("mis_buserr", bus_err, 0);
      return;
    end
    acked = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      tick();
      acked = (waits < TO) && (c == 1 + waits);
      mem_ack = acked;
      mem_rdata = acked ? rw : $urandom;
      #1;
      chk("busy_mreq", mem_req, 1);
      chk("busy_stall", stall, 1);
      chk("busy_we", mem_we, we);
      chk("busy_addr", mem_addr, a & 32'hFFFF_FFFC);
      chk("busy_be", mem_be, ebe);
      if (we) chk("busy_wdata", mem_wdata, model_wdata(t, w));
      chk("busy_done", done, 0);
      chk("busy_rdata", rdata, exp_rdata);
      if (acked) break;
    end
    tick();
    mem_ack = 1'($urandom);
    mem_rdata = $urandom;
    #1;
    if (acked) begin
      if (!we) exp_rdata = model_load(t, a, rw);
      chk("done", done, 1);
      chk("done_buserr", bus_err, 0);
    end else begin
      chk("buserr", bus_err, 1);
      chk("to_done", done, 0);
    end
    chk("end_rdata", rdata, exp_rdata);
    chk("end_stall", stall, 0);
    chk("end_mreq", mem_req, 0);
    chk("end_misalign", misalign, 0);
  endtask

  initial begin
    logic we;
    logic [2:0] t;
    logic [31:0] a;
    logic [2:0] st_codes [3];
    st_codes[0] = ST_WORD; st_codes[1] = ST_HALF; st_codes[2] = ST_BYTE;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_mreq", mem_req, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_addr", mem_addr, 0);
    run_txn(1'b0, LD_BYTE, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0);
    run_txn(1'b1, ST_HALF, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 3);
    run_txn(1'b0, LD_WORD, 32'h0000_0001, 32'h0, 32'h0, 0);
    run_txn(1'b0, LD_WORD, 32'h0000_0100, 32'h0, 32'h1234_5678, 9);
    run_txn(1'b0, LD_HALFU, 32'h0000_0042, 32'h0, 32'h8765_4321, TO - 1);
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom);
      t = we ? st_codes[$urandom_range(0, 2)] : 3'($urandom_range(0, 5));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(t) - 1);
      if ($urandom_range(0, 2) == 0) begin
        tick();
        req_valid = 1'b0; mem_ack = 1'($urandom);
        #1;
        chk("gap_stall", stall, 0);
        chk("gap_mreq", mem_req, 0);
        chk("gap_done", done, 0);
      end
      run_txn(we, t, a, $urandom, $urandom, $urandom_range(0, TO + 2));
    end
    run_txn(1'b0, LD_WORD, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 1);
    tick();
    req_valid = 1'b1; req_we = 1'b1; req_type = ST_WORD; req_addr = 32'h40; req_wdata = 32'h1111_2222;
    mem_ack = 1'b0;
    #1;
    tick();
    #1;
    chk("rb_mreq_c1", mem_req, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("rb_mreq_c2", mem_req, 1);
    tick();
    rst = 1'b0; req_valid = 1'b0; mem_ack = 1'b1;
    exp_rdata = '0;
    #1;
    chk("rb_mreq_c3", mem_req, 0);
    chk("rb_stall_c3", stall, 0);
    chk("rb_rdata", rdata, exp_rdata);
    chk("rb_be", mem_be, 0);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("rb_done", done, 0);
    chk("rb_mreq_c4", mem_req, 0);
    chk("rb_buserr", bus_err, 0);
    run_txn(1'b0, LD_BYTEU, 32'h0000_0007, 32'h0, 32'h9A00_0000, 2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencing controller between the CPU memory stage and a word-wide data memory with variable wait states. Accepts one load or store per request and stalls the pipeline until the memory acknowledges. Generates byte enables and lane-replicated write data for sub-word stores, and returns sign- or zero-extended load data. Detects misaligned accesses and memory timeouts, and reports both as errors.

## Interface
Parameters:
- TIMEOUT, default 255: max BUSY cycles without mem_ack before abort; range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU access request; held high until done, misalign or bus_err.
- req_we  in  1  1 = store, 0 = load.
- req_type  in  3  load code (LoadWord/HalfWord/HalfWordU/Byte/ByteU) or store code (StoreWord/HalfWord/Byte).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- stall  out  1  freeze the pipeline.
- done  out  1  one-cycle pulse; access complete.
- rdata  out  32  extracted load data; valid while done=1 and held until the next load completes.
- misalign  out  1  one-cycle pulse; access rejected.
- bus_err  out  1  one-cycle pulse; timeout abort.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  write strobe.
- mem_addr  out  32  {addr[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory done; read data valid in the same cycle.
- mem_rdata  in  32  read word.

## Operation
- States: IDLE, BUSY, RESP, ERR.
- IDLE, req_valid=1, aligned: latch we/type/addr/wdata, clear timer, go to BUSY.
- IDLE, req_valid=1, misaligned: go to ERR with err_kind=misalign. No memory transaction.
- Misaligned means: half with addr[0]=1, or word with addr[1:0]≠0. Byte accesses never misalign.
- BUSY: mem_req=1, all mem_* outputs driven from latched values.
  - mem_ack=1: register extracted data into rdata if load, then go to RESP.
  - Otherwise timer+1. If the timer reaches TIMEOUT, go to ERR with err_kind=bus.
- RESP: done=1, then IDLE.
- ERR: misalign or bus_err=1 according to err_kind, then IDLE.
- stall = (IDLE & req_valid) | BUSY. stall=0 in RESP and ERR, so the CPU advances.
- A req_valid seen in RESP or ERR is ignored. The next request is sampled in IDLE.
- Store byte enables:
  - word: 1111.
  - half: addr[1]=0 gives 0011, =1 gives 1100.
  - byte: 0001 << addr[1:0].
  - Loads: mem_be=1111.
- Store data: word passes through; half is {2{wdata[15:0]}}; byte is {4{wdata[7:0]}}.
- Load extract, by addr[1:0]:
  - word: whole word.
  - half: lane 0 or 2, sign- or zero-extended to 32.
  - byte: lane 0..3, sign- or zero-extended to 32.
  - Unknown type code: whole word.
- Reset values: state IDLE, timer 0, rdata 0, all outputs 0.

## Timing
- Zero-wait memory:
  - Request sampled at cycle 0.
  - mem_req high at cycle 1, with mem_ack at cycle 1.
  - done and rdata at cycle 2.
  - stall high in cycles 0–1.
- N wait states: done at cycle 2+N.
- Misaligned: misalign at cycle 1, stall high in cycle 0 only.
- Timeout: bus_err in the cycle after the TIMEOUT-th un-acked BUSY cycle; mem_req drops in that same cycle.
- mem_ack is ignored outside BUSY.
- mem_ack in the same cycle the timer would expire: ack wins, and the state goes to RESP.
- rst in BUSY: the next edge gives IDLE and mem_req=0. The memory must tolerate an abandoned request. A pending ack is discarded.
- rst has priority over all transitions.

## Structure
- The shared define header holds:
  - load and store type codes, next to the existing load codes;
  - state encodings (2-bit);
  - err_kind encoding.
- Sub-module load_lane_extract (combinational): type, addr[1:0] and mem_rdata in, extracted word out. It is instantiated once in the BUSY capture path.
- Store byte-enable and replication logic stays inline.

## Test plan
- Load byte (LoadByte) at addr 0x1003, mem_rdata=0x80FF_1234, ack with 0 waits -> mem_addr=0x1000, mem_be=1111, done at cycle 2, rdata=0xFFFF_FF80.
- Store half at addr 0x2002, wdata=0x0000_BEEF, ack after 3 waits -> mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_we=1, stall high cycles 0–4, done at cycle 5.
- Load word at addr 0x0001 -> misalign pulse at cycle 1, mem_req never high, stall high cycle 0 only.
- TIMEOUT=4, load with no ack -> mem_req high cycles 1–4, bus_err at cycle 5, done never asserted.
- rst asserted at cycle 2 of a waiting store -> state IDLE and mem_req=0 at cycle 3; a later ack is ignored; rdata=0.
- Back-to-back: req_valid held through RESP with new fields -> second access sampled the cycle after done; rdata of the first load stays stable until the second completes.
